// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, x/y counters, registered decodes,
// line/frame markers, frame counter and a pixel-delayed copy of de/hsync/vsync.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   CLK_DIV    = 4,
    parameter int   SYNC_DELAY = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic       pix_tick_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_cnt_o,
    output logic       de_d_o,
    output logic       hsync_d_o,
    output logic       vsync_d_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic             SYNC_IDLE = ~SYNC_POL;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             de_q, de_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             tick;
    logic             x_wrap;
    logic             y_wrap;

    function automatic logic in_window(input logic [9:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        div_d  = div_q;
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        tick   = en_i && (div_q == DIV_LAST);
        x_wrap = (x_q == X_LAST);
        y_wrap = (y_q == Y_LAST);

        if (en_i) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
                if (y_wrap) begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
        end

        // Decodes are taken from the next x/y so the registered levels carry no skew.
        de_d    = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
        hsync_d = in_window(x_d, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : SYNC_IDLE;
        vsync_d = in_window(y_d, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : SYNC_IDLE;
        ls_d    = tick && x_wrap;
        fs_d    = tick && x_wrap && y_wrap;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            div_q   <= '0;
            x_q     <= X_LAST;
            y_q     <= Y_LAST;
            fcnt_q  <= 8'hFF;
            de_q    <= 1'b0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fcnt_q  <= fcnt_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign pix_tick_o    = tick;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign line_start_o  = ls_q && en_i;
    assign frame_start_o = fs_q && en_i;
    assign frame_cnt_o   = fcnt_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign de_d_o    = de_q;
            assign hsync_d_o = hsync_q;
            assign vsync_d_o = vsync_q;
        end else begin : g_delay
            logic [2:0] dly_q [SYNC_DELAY];

            always_ff @(posedge clk) begin
                // NOTE: the delay line is reset too, so delayed outputs start idle instead of unknown.
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dly_q[i] <= {1'b0, SYNC_IDLE, SYNC_IDLE};
                    end
                end else if (tick) begin
                    dly_q[0] <= {de_q, hsync_q, vsync_q};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign {de_d_o, hsync_d_o, vsync_d_o} = dly_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full 640x480, and a tiny raster at two
// divider/delay settings) checked every sampled clk against a pixel-index model.
module tb_vga_timing_gen;

    localparam int ND = 3;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic       ded;
        logic       hsd;
        logic       vsd;
    } obs_t;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb, cd, sd;
        logic pol;
    } cfg_t;

    logic       clk;
    logic       rst_n [ND];
    logic       en    [ND];
    logic       pt_w  [ND];
    logic [9:0] x_w   [ND];
    logic [9:0] y_w   [ND];
    logic       de_w  [ND];
    logic       hs_w  [ND];
    logic       vs_w  [ND];
    logic       ls_w  [ND];
    logic       fs_w  [ND];
    logic [7:0] fc_w  [ND];
    logic       ded_w [ND];
    logic       hsd_w [ND];
    logic       vsd_w [ND];

    cfg_t   cfg [ND];
    longint n   [ND];
    logic   lt  [ND];
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    vga_timing_gen dut0 (
        .clk(clk), .rst_n(rst_n[0]), .en_i(en[0]), .pix_tick_o(pt_w[0]),
        .x_o(x_w[0]), .y_o(y_w[0]), .de_o(de_w[0]), .hsync_o(hs_w[0]), .vsync_o(vs_w[0]),
        .line_start_o(ls_w[0]), .frame_start_o(fs_w[0]), .frame_cnt_o(fc_w[0]),
        .de_d_o(ded_w[0]), .hsync_d_o(hsd_w[0]), .vsync_d_o(vsd_w[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .SYNC_DELAY(2), .SYNC_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .en_i(en[1]), .pix_tick_o(pt_w[1]),
        .x_o(x_w[1]), .y_o(y_w[1]), .de_o(de_w[1]), .hsync_o(hs_w[1]), .vsync_o(vs_w[1]),
        .line_start_o(ls_w[1]), .frame_start_o(fs_w[1]), .frame_cnt_o(fc_w[1]),
        .de_d_o(ded_w[1]), .hsync_d_o(hsd_w[1]), .vsync_d_o(vsd_w[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_DELAY(0), .SYNC_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .en_i(en[2]), .pix_tick_o(pt_w[2]),
        .x_o(x_w[2]), .y_o(y_w[2]), .de_o(de_w[2]), .hsync_o(hs_w[2]), .vsync_o(vs_w[2]),
        .line_start_o(ls_w[2]), .frame_start_o(fs_w[2]), .frame_cnt_o(fc_w[2]),
        .de_d_o(ded_w[2]), .hsync_d_o(hsd_w[2]), .vsync_d_o(vsd_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n = enabled edges since reset; lt = the previous edge was an enabled pixel tick.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n[d]) begin
                n[d]  <= 0;
                lt[d] <= 1'b0;
            end else begin
                lt[d] <= en[d] && (n[d] % cfg[d].cd == longint'(cfg[d].cd - 1));
                if (en[d]) n[d] <= n[d] + 1;
            end
        end
        cyc <= cyc + 1;
    end

    function automatic obs_t observe(input int d);
        return {pt_w[d], x_w[d], y_w[d], de_w[d], hs_w[d], vs_w[d], ls_w[d], fs_w[d],
                fc_w[d], ded_w[d], hsd_w[d], vsd_w[d]};
    endfunction

    // Levels for global pixel index g (g<0 means "before the first pixel": idle).
    function automatic logic [2:0] decode(input cfg_t c, input longint g);
        longint ht, vt, px, ln;
        logic   h_on, v_on;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        if (g < 0) return {1'b0, ~c.pol, ~c.pol};
        px   = g % ht;
        ln   = (g / ht) % vt;
        h_on = (px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs);
        v_on = (ln >= c.va + c.vf) && (ln < c.va + c.vf + c.vs);
        return {(px < c.ha) && (ln < c.va), h_on ? c.pol : ~c.pol, v_on ? c.pol : ~c.pol};
    endfunction

    function automatic obs_t expect_of(input int d);
        cfg_t   c;
        obs_t   e;
        longint ht, vt, g;
        c  = cfg[d];
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        g  = n[d] / c.cd - 1;
        e.pt = en[d] && (n[d] % c.cd == longint'(c.cd - 1));
        if (g < 0) begin
            e.x  = 10'(ht - 1);
            e.y  = 10'(vt - 1);
            e.fc = 8'hFF;
        end else begin
            e.x  = 10'(g % ht);
            e.y  = 10'((g / ht) % vt);
            e.fc = 8'((g / (ht * vt)) % 256);
        end
        {e.de, e.hs, e.vs}    = decode(c, g);
        {e.ded, e.hsd, e.vsd} = decode(c, g - c.sd);
        e.ls = en[d] && lt[d] && (e.x == 10'd0);
        e.fs = e.ls && (e.y == 10'd0);
        return e;
    endfunction

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0;
            en[d]    = 1'b1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({x_w[0], y_w[0], de_w[0], hs_w[0], vs_w[0]} !== {10'd799, 10'd524, 3'b011}) begin
            failures++;
            $display("FAIL reset_values actual x=%0d y=%0d de=%b hs=%b vs=%b required x=799 y=524 de=0 hs=1 vs=1",
                     x_w[0], y_w[0], de_w[0], hs_w[0], vs_w[0]);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (observe(d) !== expect_of(d)) begin
                failures++;
                $display("FAIL reset_model dut%0d actual=%h required=%h", d, observe(d), expect_of(d));
            end
            rst_n[d] = 1'b1;
        end
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            checks++;
            if (observe(0) !== expect_of(0)) begin
                failures++;
                $display("FAIL reset_release_model t=%0d actual=%h required=%h", t, observe(0), expect_of(0));
            end
            checks++;
            if (fs_w[0] !== (t == 4)) begin
                failures++;
                $display("FAIL reset_frame_start t=%0d actual=%b required=%b", t, fs_w[0], t == 4);
            end
        end
        checks++;
        if ({x_w[0], y_w[0], fc_w[0], de_w[0]} !== {10'd0, 10'd0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_first_pixel actual x=%0d y=%0d fc=%0d de=%b required 0 0 0 1",
                     x_w[0], y_w[0], fc_w[0], de_w[0]);
        end
    endtask

    task automatic test_line_timing();
        int   t, fall_t, hs_low, de_cnt, next_t;
        logic hs_prev, found;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (ls_w[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL line_wait_timeout actual=no line_start required=line_start within 4000 clks");
        end
        fall_t  = -1;
        hs_low  = 0;
        de_cnt  = de_w[0] ? 1 : 0;
        next_t  = -1;
        hs_prev = hs_w[0];
        for (t = 1; t <= 4000 && next_t < 0; t++) begin
            @(negedge clk);
            checks++;
            if (observe(0) !== expect_of(0)) begin
                failures++;
                $display("FAIL line_model t=%0d actual=%h required=%h", t, observe(0), expect_of(0));
            end
            if (ls_w[0]) next_t = t;
            else begin
                if (hs_prev && !hs_w[0] && fall_t < 0) fall_t = t;
                if (!hs_w[0]) hs_low++;
                if (de_w[0]) de_cnt++;
            end
            hs_prev = hs_w[0];
        end
        checks++;
        if (fall_t != 2624) begin
            failures++;
            $display("FAIL line_hsync_fall actual=%0d required=2624", fall_t);
        end
        checks++;
        if (hs_low != 384) begin
            failures++;
            $display("FAIL line_hsync_width actual=%0d required=384", hs_low);
        end
        checks++;
        if (de_cnt != 2560) begin
            failures++;
            $display("FAIL line_de_width actual=%0d required=2560", de_cnt);
        end
        checks++;
        if (next_t != 3200) begin
            failures++;
            $display("FAIL line_period actual=%0d required=3200", next_t);
        end
    endtask

    task automatic test_enable_pause();
        int   t, next_t, hs_low, de_cnt;
        logic paused, found;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (ls_w[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pause_wait_timeout actual=no line_start required=line_start within 4000 clks");
        end
        t      = 0;
        next_t = -1;
        hs_low = 0;
        de_cnt = de_w[0] ? 1 : 0;
        paused = 1'b0;
        while (t < 4000 && next_t < 0) begin
            if (!paused && x_w[0] == 10'd100) begin
                paused = 1'b1;
                en[0]  = 1'b0;
                repeat (37) begin
                    @(negedge clk);
                    t++;
                    checks++;
                    if (observe(0) !== expect_of(0)) begin
                        failures++;
                        $display("FAIL pause_model t=%0d actual=%h required=%h", t, observe(0), expect_of(0));
                    end
                    checks++;
                    if ({x_w[0], de_w[0], hs_w[0], pt_w[0], ls_w[0], fs_w[0]} !== {10'd100, 5'b11000}) begin
                        failures++;
                        $display("FAIL pause_hold t=%0d actual x=%0d de=%b hs=%b pt=%b ls=%b fs=%b required x=100 de=1 hs=1 pt=0 ls=0 fs=0",
                                 t, x_w[0], de_w[0], hs_w[0], pt_w[0], ls_w[0], fs_w[0]);
                    end
                    if (de_w[0]) de_cnt++;
                    if (!hs_w[0]) hs_low++;
                end
                en[0] = 1'b1;
            end
            @(negedge clk);
            t++;
            checks++;
            if (observe(0) !== expect_of(0)) begin
                failures++;
                $display("FAIL pause_model t=%0d actual=%h required=%h", t, observe(0), expect_of(0));
            end
            if (ls_w[0]) next_t = t;
            else begin
                if (de_w[0]) de_cnt++;
                if (!hs_w[0]) hs_low++;
            end
        end
        checks++;
        if (next_t != 3237) begin
            failures++;
            $display("FAIL pause_line_period actual=%0d required=3237", next_t);
        end
        checks++;
        if (hs_low != 384 || de_cnt != 2597) begin
            failures++;
            $display("FAIL pause_widths actual hs_low=%0d de=%0d required hs_low=384 de=2597", hs_low, de_cnt);
        end
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (observe(0) !== expect_of(0)) begin
                failures++;
                $display("FAIL random_model i=%0d actual=%h required=%h", i, observe(0), expect_of(0));
            end
            en[0]    = ($urandom_range(0, 3) != 0);
            rst_n[0] = ($urandom_range(0, 499) != 0);
        end
        en[0]    = 1'b1;
        rst_n[0] = 1'b1;
    endtask

    task automatic test_delay_align();
        int   de_t, ded_t, hs_t, hsd_t;
        logic de_p, ded_p, hs_p, hsd_p;
        rst_n[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        de_t = -1; ded_t = -1; hs_t = -1; hsd_t = -1;
        {de_p, ded_p, hs_p, hsd_p} = {de_w[1], ded_w[1], hs_w[1], hsd_w[1]};
        for (int t = 1; t <= 800; t++) begin
            @(negedge clk);
            checks++;
            if (observe(1) !== expect_of(1)) begin
                failures++;
                $display("FAIL delay_model t=%0d actual=%h required=%h", t, observe(1), expect_of(1));
            end
            if (!de_p && de_w[1] && de_t < 0) de_t = t;
            if (!ded_p && ded_w[1] && ded_t < 0) ded_t = t;
            if (hs_p && !hs_w[1] && hs_t < 0) hs_t = t;
            if (hsd_p && !hsd_w[1] && hsd_t < 0) hsd_t = t;
            {de_p, ded_p, hs_p, hsd_p} = {de_w[1], ded_w[1], hs_w[1], hsd_w[1]};
        end
        checks++;
        if (de_t != 4 || ded_t != 12) begin
            failures++;
            $display("FAIL delay_de_rise actual de=%0d de_d=%0d required de=4 de_d=12", de_t, ded_t);
        end
        checks++;
        if (hs_t < 0 || hsd_t - hs_t != 8) begin
            failures++;
            $display("FAIL delay_hsync_lag actual hs=%0d hs_d=%0d required lag of 8", hs_t, hsd_t);
        end
    endtask

    task automatic test_sync_delay0();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            checks++;
            if (observe(2) !== expect_of(2)) begin
                failures++;
                $display("FAIL nodelay_model t=%0d actual=%h required=%h", t, observe(2), expect_of(2));
            end
        end
    endtask

    task automatic test_frame();
        int   frame_idx, de_cnt, vs_cnt;
        logic wrapped;
        rst_n[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        frame_idx = -1;
        de_cnt    = 0;
        vs_cnt    = 0;
        wrapped   = 1'b0;
        for (int t = 1; t <= 260 * 170 && !wrapped; t++) begin
            @(negedge clk);
            checks++;
            if (observe(2) !== expect_of(2)) begin
                failures++;
                $display("FAIL frame_model t=%0d actual=%h required=%h", t, observe(2), expect_of(2));
            end
            if (t <= 17) begin
                checks++;
                if (pt_w[2] !== 1'b1 || x_w[2] !== 10'(t - 1)) begin
                    failures++;
                    $display("FAIL frame_div1_advance t=%0d actual pt=%b x=%0d required pt=1 x=%0d", t, pt_w[2], x_w[2], t - 1);
                end
            end
            if (fs_w[2]) begin
                if (frame_idx == 0) begin
                    checks++;
                    if (de_cnt != 60 || vs_cnt != 34) begin
                        failures++;
                        $display("FAIL frame_counts actual de=%0d vs=%0d required de=60 vs=34", de_cnt, vs_cnt);
                    end
                end
                frame_idx++;
                de_cnt = 0;
                vs_cnt = 0;
                checks++;
                if (fc_w[2] !== 8'(frame_idx)) begin
                    failures++;
                    $display("FAIL frame_cnt frame=%0d actual=%0d required=%0d", frame_idx, fc_w[2], 8'(frame_idx));
                end
                if (frame_idx == 256) wrapped = 1'b1;
            end
            if (de_w[2]) de_cnt++;
            if (vs_w[2]) vs_cnt++;
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("FAIL frame_wrap_timeout actual frames=%0d required=256", frame_idx);
        end
    endtask

    task automatic test_mid_reset();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (x_w[2] == 10'd5 && y_w[2] == 10'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_wait_timeout actual=position not reached required=(5,3)");
        end
        rst_n[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        checks++;
        if ({x_w[2], y_w[2], fc_w[2], de_w[2], hs_w[2], vs_w[2], ls_w[2], fs_w[2]} !==
            {10'd16, 10'd9, 8'hFF, 5'b00000}) begin
            failures++;
            $display("FAIL midreset_values actual x=%0d y=%0d fc=%0d de=%b hs=%b vs=%b ls=%b fs=%b required 16 9 255 0 0 0 0 0",
                     x_w[2], y_w[2], fc_w[2], de_w[2], hs_w[2], vs_w[2], ls_w[2], fs_w[2]);
        end
        @(negedge clk);
        checks++;
        if ({x_w[2], y_w[2], fc_w[2], fs_w[2]} !== {10'd0, 10'd0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_restart actual x=%0d y=%0d fc=%0d fs=%b required 0 0 0 1",
                     x_w[2], y_w[2], fc_w[2], fs_w[2]);
        end
        checks++;
        if (observe(2) !== expect_of(2)) begin
            failures++;
            $display("FAIL midreset_model actual=%h required=%h", observe(2), expect_of(2));
        end
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 1'b0};
        cfg[1] = '{10, 2, 3, 2, 6, 1, 2, 1, 4, 2, 1'b0};
        cfg[2] = '{10, 2, 3, 2, 6, 1, 2, 1, 1, 0, 1'b1};
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0;
            en[d]    = 1'b1;
        end
        test_reset();
        test_line_timing();
        test_enable_pause();
        test_random_enable();
        test_delay_align();
        test_sync_delay0();
        test_frame();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=time limit reached required=bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 raster scan that drives every UI renderer (flag, icons, background) in the VGA path. Produces the pixel coordinates `x`/`y` consumed combinationally by the renderers, plus data-enable, sync, and frame/line markers. Also produces a copy of `de`/`hsync`/`vsync` delayed by a fixed number of pixels, so sync stays aligned with the registered compositor stage downstream of the renderers.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync lengths (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync lengths (lines)
- `CLK_DIV`, 4, clk cycles per pixel (1..8); 100 MHz → 25 MHz pixel rate
- `SYNC_DELAY`, 1, pixel periods of delay on `*_d` outputs (0..3)
- `SYNC_POL`, 0, active level of `hsync`/`vsync` (0 = active-low)
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `en`  in  1  advance enable; low freezes all state
- `pix_tick`  out  1  high in the last clk of each pixel period (counters advance on the following edge)
- `x`  out  10  horizontal counter, 0..H_TOTAL-1
- `y`  out  10  vertical counter, 0..V_TOTAL-1
- `de`  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- `hsync`, `vsync`  out  1 each  sync outputs at polarity SYNC_POL
- `line_start`  out  1  one-clk pulse in the first clk where x=0
- `frame_start`  out  1  one-clk pulse in the first clk where x=0, y=0
- `frame_cnt`  out  8  frame counter, wraps
- `de_d`, `hsync_d`, `vsync_d`  out  1 each  delayed copies

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1 while `en`=1. `pix_tick` = `en` && `div`==CLK_DIV-1. With CLK_DIV=1, `pix_tick`=`en`.
- On an edge where `pix_tick`=1:
  - x ← x+1, or 0 at H_TOTAL-1.
  - When x wraps, y ← y+1, or 0 at V_TOTAL-1.
  - On the (H_TOTAL-1, V_TOTAL-1)→(0,0) transition, `frame_cnt` ← `frame_cnt`+1 (mod 256).
- Sync windows:
  - `hsync` is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - `vsync` is active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492). Vsync is line-based, independent of x.
- `de`, `hsync`, and `vsync` are registered. In every clk they equal the decode of the current x/y, with zero skew to x/y.
- `line_start` and `frame_start` are registered. Each is high only in the first clk after the advancing edge that produced x=0 (or x=0, y=0). They are never repeated across the remaining CLK_DIV-1 clks.
- Delay line: a SYNC_DELAY-deep shift register per signal, shifting on `pix_tick` edges. `*_d` equals the corresponding signal as it was SYNC_DELAY pixel periods earlier. SYNC_DELAY=0 means `*_d` are wires from `de`/`hsync`/`vsync`.
- `en`=0:
  - `div`, x, y, `frame_cnt`, and the delay line hold.
  - `pix_tick`, `line_start`, and `frame_start` are 0.
  - Level outputs hold.

## Timing
- Reset (`rst_n` sampled low) sets:
  - `div`=0, x=H_TOTAL-1, y=V_TOTAL-1, `frame_cnt`=8'hFF.
  - `de`=0, `hsync`/`vsync`=inactive.
  - Delay line filled with `de`=0 and inactive sync.
  - `pix_tick`=0, `line_start`=0, `frame_start`=0.
- Because of these reset values, the first tick after reset lands on (0,0): `frame_start` pulses and `frame_cnt` becomes 0.
- Reset mid-frame has priority over `en` and `pix_tick`. Everything returns to the reset values on that edge, with no partial pulse.
- Latency:
  - x/y change exactly one edge after `pix_tick`.
  - Pulses and decodes are valid in the same clk as the new x/y.
  - `*_d` lag by SYNC_DELAY×CLK_DIV clks when `en` is held high.
- One line = H_TOTAL×CLK_DIV clks. One frame = H_TOTAL×V_TOTAL×CLK_DIV clks (1,680,000 at defaults).
- Simultaneous events: the x wrap, y wrap, and `frame_cnt` increment all happen on the same edge. `line_start` and `frame_start` are both high in the following clk.

## Test plan
- Reset check: hold `rst_n`=0 for 3 clks, release with `en`=1, defaults.
  - During reset: x=799, y=524, `de`=0, `hsync`=`vsync`=1.
  - After release: `frame_start` pulses 4 clks later with x=0, y=0, `frame_cnt`=0, `de`=1.
- Line timing, defaults: from `line_start`, `hsync` falls after 656×4=2624 clks and stays low 384 clks. `de` is high for 2560 clks. The next `line_start` comes 3200 clks after the first.
- Frame timing:
  - `vsync` low exactly for y=490..491 (6400 clks).
  - 256 frames in, `frame_cnt` wraps 255→0 with `frame_start`.
  - `de` count per frame = 307200 pixels.
- Enable pause: drop `en` for 37 clks mid-line at x=100. x, `div`, and sync hold, and there are no pulses. On resume the line completes 37 clks late with correct widths.
- Delay alignment, SYNC_DELAY=2, CLK_DIV=4: `de_d` rises exactly 8 clks after `de`, and `hsync_d` trails `hsync` by 8 clks. With SYNC_DELAY=0, `*_d` match `de`/`hsync`/`vsync` every clk.
- CLK_DIV=1 plus mid-frame reset:
  - Before reset: `pix_tick` is constant high and x advances every clk.
  - Assert `rst_n`=0 at (300,200) for one edge: the next clk shows reset values.
  - After release: the frame restarts with `frame_cnt`=0.
